ysyx_23060075_mem_arbiter: RTL
==============================

YSYX_23060075_MEM_ARBITER -- requirements
Module: ysyx_23060075_mem_arbiter

Interface
REQ-001 Parameter N_CH, default 2, number of requester channels (legal 1..8).
REQ-002 Parameter DW, default 32, data width (legal 32 or 64).
REQ-003 Parameter AW, default 32, address width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 m_req_valid  input  N_CH  per-channel request valid.
REQ-007 m_req_ready  output  N_CH  per-channel request accepted (one-hot or zero).
REQ-008 m_addr  input  N_CH*AW  per-channel byte address; channel i at bits [i*AW +: AW].
REQ-009 m_wen  input  N_CH  per-channel write (1) / read (0).
REQ-010 m_size  input  N_CH*2  per-channel access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-011 m_wdata  input  N_CH*DW  per-channel write data.
REQ-012 m_wmask  input  N_CH*DW/8  per-channel byte write mask.
REQ-013 m_rsp_valid  output  N_CH  per-channel response valid (one-hot or zero).
REQ-014 m_rsp_ready  input  N_CH  per-channel response accept.
REQ-015 m_rdata  output  DW  response read data, shared by all channels.
REQ-016 m_rsp_err  output  1  response error flag, shared by all channels.
REQ-017 mem_req_valid  output  1  downstream request valid.
REQ-018 mem_req_ready  input  1  downstream request accept.
REQ-019 mem_addr, mem_wen, mem_wdata, mem_wmask  output  AW, 1, DW, DW/8  downstream request fields.
REQ-020 mem_rsp_valid  input  1  downstream response valid, one-cycle pulse.
REQ-021 mem_rdata  input  DW  downstream read data, valid with mem_rsp_valid.
REQ-022 err_cnt  output  8  count of error responses.

Function
REQ-023 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-024 IDLE: if any m_req_valid, grant SHALL go to the first valid channel searching upward from rr_ptr with wrap; m_req_ready[g]=1 combinationally that cycle; address, wen, size, wdata and wmask latched.
REQ-025 m_req_ready SHALL be zero in every state other than IDLE.
REQ-026 IDLE->ISSUE on grant (legal access); ISSUE drives mem_req_valid=1 with latched fields, held stable until mem_req_ready.
REQ-027 ISSUE->WAIT on mem_req_ready=1; WAIT->RESP on mem_rsp_valid=1, mem_rdata latched into m_rdata.
REQ-028 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-029 RESP: m_rsp_valid[g]=1, m_rdata and m_rsp_err stable; on m_rsp_ready[g] -> IDLE, rr_ptr = (g+1) mod N_CH.
REQ-030 Minimum latency: accept at cycle 0, mem_req_valid at cycle 1, m_rsp_valid at cycle 3 when mem_req_ready=1 and mem_rsp_valid arrive immediately.
REQ-031 Writes SHALL also wait for mem_rsp_valid; m_rdata for writes is don't-care.
REQ-032 Misaligned: addr mod 2^size != 0; size 3 with DW=32 is also illegal.
REQ-033 A new request arriving in RESP SHALL wait; back-to-back grant earliest the cycle after RESP exits.

Reset
REQ-034 On rst=0 at a rising edge: state IDLE, rr_ptr 0, err_cnt 0, m_rdata 0, m_rsp_err 0; all valid/ready outputs 0 during and after reset.
REQ-035 Reset mid-transaction SHALL abandon it without a response; a late mem_rsp_valid after reset is ignored.

Configuration
REQ-036 Macro YSYX_23060075_MEM_ALIGN_CHECK_EN defined: an illegal access (REQ-032) goes IDLE->RESP directly, with no downstream request, m_rsp_err=1, m_rdata=0; err_cnt increments, saturating at 255.
REQ-037 Macro undefined: all accesses forwarded downstream unmodified; m_rsp_err=0 and err_cnt=0 always.

Verification
REQ-038 N_CH=2, ch0 read addr 0x80000000 size 2, mem ready/response immediate, mem_rdata 0xDEADBEEF -> m_rsp_valid[0] at cycle 3, m_rdata 0xDEADBEEF, err 0.
REQ-039 Both channels valid continuously, reads -> grants alternate ch0, ch1, ch0, ch1; never two grants outstanding.
REQ-040 Macro defined: ch1 write addr 0x80000002 size 2 -> no mem_req_valid, m_rsp_valid[1] with err 1 next cycle, err_cnt 1; macro undefined -> forwarded, err 0.
REQ-041 mem_req_ready held 0 for 5 cycles -> mem_addr/mem_wdata stable across all 5 cycles; m_rsp_ready held 0 -> m_rsp_valid held, no new grant.
REQ-042 rst=0 asserted in WAIT, then mem_rsp_valid pulse -> no m_rsp_valid, state IDLE, err_cnt 0.
REQ-043 Macro defined: 300 misaligned accesses -> err_cnt saturates at 255.

Source files
------------

// File: rtl/ysyx_23060075_mem_arbiter.sv
// Round-robin N_CH-to-1 memory arbiter with a single outstanding transaction.
// Optional misalignment trapping enabled by defining YSYX_23060075_MEM_ALIGN_CHECK_EN.
module ysyx_23060075_mem_arbiter #(
    parameter int N_CH = 2,
    parameter int DW   = 32,
    parameter int AW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      m_req_valid,
    output logic [N_CH-1:0]      m_req_ready,
    input  logic [N_CH*AW-1:0]   m_addr,
    input  logic [N_CH-1:0]      m_wen,
    input  logic [N_CH*2-1:0]    m_size,
    input  logic [N_CH*DW-1:0]   m_wdata,
    input  logic [N_CH*DW/8-1:0] m_wmask,
    output logic [N_CH-1:0]      m_rsp_valid,
    input  logic [N_CH-1:0]      m_rsp_ready,
    output logic [DW-1:0]        m_rdata,
    output logic                 m_rsp_err,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_wen,
    output logic [DW-1:0]        mem_wdata,
    output logic [DW/8-1:0]      mem_wmask,
    input  logic                 mem_rsp_valid,
    input  logic [DW-1:0]        mem_rdata,
    output logic [7:0]           err_cnt
);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int MW = DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]   wmask_q, wmask_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            found_s;
    logic [PW-1:0]   gnt_idx_s;
    logic [AW-1:0]   sel_addr_s;
    logic            sel_wen_s;
    logic [1:0]      sel_size_s;
    logic [DW-1:0]   sel_wdata_s;
    logic [MW-1:0]   sel_wmask_s;
    logic [N_CH-1:0] m_req_ready_s;
    logic [N_CH-1:0] m_rsp_valid_s;

`ifdef YSYX_23060075_MEM_ALIGN_CHECK_EN
    // A dword access cannot be carried on a 32-bit data path.
    function automatic logic misaligned(input logic [AW-1:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = |a[1:0];
            2'd3:    misaligned = (|a[2:0]) || (DW == 32);
            default: misaligned = 1'b1;
        endcase
    endfunction
`else
    logic unused_size_s;
    assign unused_size_s = ^sel_size_s;
`endif

    // Round-robin search: first valid channel at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        found_s     = 1'b0;
        gnt_idx_s   = '0;
        sel_addr_s  = '0;
        sel_wen_s   = 1'b0;
        sel_size_s  = 2'd0;
        sel_wdata_s = '0;
        sel_wmask_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end else begin
                idx = idx;
            end
            if (!found_s && m_req_valid[idx]) begin
                found_s     = 1'b1;
                gnt_idx_s   = PW'(idx);
                sel_addr_s  = m_addr[idx*AW +: AW];
                sel_wen_s   = m_wen[idx];
                sel_size_s  = m_size[idx*2 +: 2];
                sel_wdata_s = m_wdata[idx*DW +: DW];
                sel_wmask_s = m_wmask[idx*MW +: MW];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and request-latching logic.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        err_cnt_d     = err_cnt_q;
        m_req_ready_s = '0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    m_req_ready_s[gnt_idx_s] = 1'b1;
                    gnt_d   = gnt_idx_s;
                    addr_d  = sel_addr_s;
                    wen_d   = sel_wen_s;
                    wdata_d = sel_wdata_s;
                    wmask_d = sel_wmask_s;
`ifdef YSYX_23060075_MEM_ALIGN_CHECK_EN
                    if (misaligned(sel_addr_s, sel_size_s)) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                    end else begin
                        state_d = ISSUE;
                        err_d   = 1'b0;
                    end
`else
                    state_d = ISSUE;
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = RESP;
                    rdata_d = mem_rdata;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (m_rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                    if (gnt_q == PW'(N_CH - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt_q + PW'(1);
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One-hot response valid towards the granted channel.
    always_comb begin
        m_rsp_valid_s = '0;
        if (rst && (state_q == RESP)) begin
            m_rsp_valid_s[gnt_q] = 1'b1;
        end else begin
            m_rsp_valid_s = '0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Handshake outputs are forced low while reset is asserted.
    assign m_req_ready   = rst ? m_req_ready_s : '0;
    assign m_rsp_valid   = m_rsp_valid_s;
    assign mem_req_valid = rst && (state_q == ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign m_rdata       = rdata_q;
    assign m_rsp_err     = err_q;
    assign err_cnt       = err_cnt_q;
endmodule
